rv_instr_encoder: RTL and testbench

- Streaming RV32I instruction encoder and program loader: the inverse of the core's instruction decoder.
- Accepts structured instruction fields over a valid/ready stream, packs them into 32-bit RV32I words, and writes them to sequential instruction-memory addresses.
- Used by the self-test/boot logic to place programs in IMEM. Illegal field combinations are dropped and counted.

---
 rtl/rv_instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder / program loader: packs instruction fields into 32-bit words
// and writes them to consecutive IMEM addresses, dropping and counting illegal beats.
module rv_instr_encoder #(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [3:0]          i_kind,
    input  logic [2:0]          i_funct3,
    input  logic                i_alt,
    input  logic [4:0]          i_rd,
    input  logic [4:0]          i_rs1,
    input  logic [4:0]          i_rs2,
    input  logic [31:0]         i_imm,
    input  logic                i_last,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [31:0]         o_mem_data,
    output logic                o_done,
    output logic                o_err,
    output logic [ERRCNT_W-1:0] o_err_cnt,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic                out_valid;
    logic [31:0]         out_data;
    logic                err;
    logic [ERRCNT_W-1:0] err_cnt;

    // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
    // the sender holds its payload stable until that edge and ready never depends on valid.
    logic accept, mem_fire, start_ok;
    assign accept   = i_valid && o_ready;
    assign mem_fire = out_valid && i_mem_ready;
    assign start_ok = (state == S_IDLE) && i_start;

    // Field encoding and legality checks
    logic signed [31:0] imm_s;
    logic [6:0]         f7;
    logic               in_i12, in_b13, in_j21, shamt_ok;
    logic [31:0]        enc_word;
    logic               enc_bad;

    assign imm_s    = i_imm;
    assign f7       = i_alt ? 7'b0100000 : 7'b0000000;
    assign in_i12   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign in_b13   = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !i_imm[0];
    assign in_j21   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !i_imm[0];
    assign shamt_ok = (i_imm[31:5] == 27'd0);

    always_comb begin
        enc_bad  = 1'b0;
        enc_word = 32'd0;
        case (i_kind)
            4'd0: begin
                enc_bad  = i_alt && (i_funct3 != 3'd0) && (i_funct3 != 3'd5);
                enc_word = {f7, i_rs2, i_rs1, i_funct3, i_rd, 7'b0110011};
            end
            4'd1: begin
                if ((i_funct3 == 3'd1) || (i_funct3 == 3'd5)) begin
                    enc_bad  = (i_alt && (i_funct3 != 3'd5)) || !shamt_ok;
                    enc_word = {f7, i_imm[4:0], i_rs1, i_funct3, i_rd, 7'b0010011};
                end else begin
                    enc_bad  = i_alt || !in_i12;
                    enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b0010011};
                end
            end
            4'd2: begin
                enc_bad  = (i_funct3 == 3'd3) || (i_funct3 >= 3'd6) || !in_i12;
                enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b0000011};
            end
            4'd3: begin
                enc_bad  = (i_funct3 > 3'd2) || !in_i12;
                enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], 7'b0100011};
            end
            4'd4: begin
                enc_bad  = (i_funct3 == 3'd2) || (i_funct3 == 3'd3) || !in_b13;
                enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:1], i_imm[11], 7'b1100011};
            end
            4'd5: begin
                enc_bad  = !in_j21;
                enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, 7'b1101111};
            end
            4'd6: begin
                enc_bad  = (i_funct3 != 3'd0) || !in_i12;
                enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b1100111};
            end
            4'd7: begin
                enc_bad  = (i_imm[11:0] != 12'd0);
                enc_word = {i_imm[31:12], i_rd, 7'b0110111};
            end
            4'd8: begin
                enc_bad  = (i_imm[11:0] != 12'd0);
                enc_word = {i_imm[31:12], i_rd, 7'b0010111};
            end
            default: enc_bad = 1'b1;
        endcase
    end

    // Session FSM
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_done    = 1'b0;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN: begin
                o_ready = !out_valid || i_mem_ready;
                if (i_valid && o_ready && i_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (!out_valid) state_nxt = S_DONE;
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The output register refills on the same edge it drains, giving one word per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                addr    <= {i_base_addr[ADDR_W-1:2], 2'b00};
                err     <= 1'b0;
                err_cnt <= '0;
            end else if (mem_fire) begin
                addr <= addr + ADDR_W'(4);
            end
            if (accept && !enc_bad) begin
                out_valid <= 1'b1;
                out_data  <= enc_word;
            end else if (mem_fire) begin
                out_valid <= 1'b0;
            end
            if (accept && enc_bad) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign o_mem_valid = out_valid;
    assign o_mem_addr  = addr;
    assign o_mem_data  = out_data;
    assign o_err       = err;
    assign o_err_cnt   = err_cnt;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed and random field streams, scoreboard of expected
// IMEM writes built from an arithmetic RV32I reference model.
module tb_rv_instr_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = 32'd0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  i_kind = 4'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic        i_alt = 1'b0;
    logic [4:0]  i_rd = 5'd0, i_rs1 = 5'd0, i_rs2 = 5'd0;
    logic [31:0] i_imm = 32'd0;
    logic        i_last = 1'b0;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b1;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_done;
    logic        o_err;
    logic [7:0]  o_err_cnt;
    logic [1:0]  o_dbg_state;

    rv_instr_encoder #(.ADDR_W(32), .ERRCNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_valid(i_valid), .o_ready(o_ready), .i_kind(i_kind), .i_funct3(i_funct3),
        .i_alt(i_alt), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .i_last(i_last), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_done(o_done), .o_err(o_err),
        .o_err_cnt(o_err_cnt), .o_dbg_state(o_dbg_state)
    );

    // clock / reset / watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_addr = 32'd0;
    int          m_cnt  = 0;
    bit          m_err  = 1'b0;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: returns {illegal, word}, built from the format rules with arithmetic.
    function automatic logic [32:0] ref_encode(input int kind, input int f3, input bit alt,
                                               input int rd, input int rs1, input int rs2,
                                               input logic [31:0] imm);
        longint s;
        longint w;
        bit     ill;
        longint f7;
        int     op_tab[9];
        op_tab = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h67, 'h37, 'h17};
        s   = longint'($signed(imm));
        ill = 1'b0;
        w   = 0;
        f7  = alt ? 32 : 0;
        if (kind > 8) return {1'b1, 32'd0};
        case (kind)
            0: begin
                if (alt && f3 != 0 && f3 != 5) ill = 1'b1;
                w = f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * 128;
            end
            1: begin
                if (alt && f3 != 5) ill = 1'b1;
                if (f3 == 1 || f3 == 5) begin
                    if (s < 0 || s > 31) ill = 1'b1;
                    w = f7 * (1 << 25) + (s & 31) * (1 << 20);
                end else begin
                    if (s < -2048 || s > 2047) ill = 1'b1;
                    w = (s & 'hFFF) * (1 << 20);
                end
                w += rs1 * (1 << 15) + f3 * (1 << 12) + rd * 128;
            end
            2, 6: begin
                if (kind == 2 && (f3 == 3 || f3 == 6 || f3 == 7)) ill = 1'b1;
                if (kind == 6 && f3 != 0) ill = 1'b1;
                if (s < -2048 || s > 2047) ill = 1'b1;
                w = (s & 'hFFF) * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * 128;
            end
            3: begin
                if (f3 > 2 || s < -2048 || s > 2047) ill = 1'b1;
                w = ((s >> 5) & 127) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                  + f3 * (1 << 12) + (s & 31) * 128;
            end
            4: begin
                if (f3 == 2 || f3 == 3 || (s % 2) != 0 || s < -4096 || s > 4094) ill = 1'b1;
                w = ((s >> 12) & 1) * (longint'(1) << 31) + ((s >> 5) & 63) * (1 << 25)
                  + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
                  + ((s >> 1) & 15) * 256 + ((s >> 11) & 1) * 128;
            end
            5: begin
                if ((s % 2) != 0 || s < -1048576 || s > 1048574) ill = 1'b1;
                w = ((s >> 20) & 1) * (longint'(1) << 31) + ((s >> 1) & 1023) * (1 << 21)
                  + ((s >> 11) & 1) * (1 << 20) + ((s >> 12) & 255) * (1 << 12) + rd * 128;
            end
            default: begin
                if ((imm % 4096) != 0) ill = 1'b1;
                w = longint'(imm) - longint'(imm % 4096) + rd * 128;
            end
        endcase
        w += op_tab[kind];
        return {ill, w[31:0]};
    endfunction

    // driver tasks
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_mem_ready = 1'b1;
            1:       i_mem_ready = 1'($urandom_range(0, 1));
            default: i_mem_ready = 1'b0;
        endcase
    end

    task automatic start_session(input logic [31:0] base);
        @(posedge i_clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = base;
        m_addr      = base & ~32'd3;
        m_cnt       = 0;
        m_err       = 1'b0;
        @(posedge i_clk);
        #1;
        i_start     = 1'b0;
        i_base_addr = $urandom;
    endtask

    task automatic send_beat(input int kind, input int f3, input bit alt, input int rd,
                             input int rs1, input int rs2, input logic [31:0] imm,
                             input bit last, input bit use_exp, input logic [31:0] exp_word);
        logic [32:0] r;
        int n;
        r        = ref_encode(kind, f3, alt, rd, rs1, rs2, imm);
        i_valid  = 1'b1;
        i_kind   = 4'(kind);
        i_funct3 = 3'(f3);
        i_alt    = alt;
        i_rd     = 5'(rd);
        i_rs1    = 5'(rs1);
        i_rs2    = 5'(rs2);
        i_imm    = imm;
        i_last   = last;
        i_start  = ($urandom_range(0, 7) == 0);  // must be ignored outside IDLE
        n = 0;
        while (1) begin
            @(negedge i_clk);
            if (o_ready) break;
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL beat_accept: no o_ready within 500 cycles");
                break;
            end
        end
        if (n <= 500) begin
            if (r[32]) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else begin
                exp_q.push_back({m_addr, use_exp ? exp_word : r[31:0]});
                m_addr += 32'd4;
            end
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (1) begin
            @(negedge i_clk);
            if (o_done) break;
            n++;
            if (n > 2000) break;
        end
        check("done_seen", 64'(o_done), 64'd1);
        check("err_flag", 64'(o_err), 64'(m_err));
        check("err_cnt", 64'(o_err_cnt), 64'(m_cnt));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        @(negedge i_clk);
        check("done_one_cycle", 64'(o_done), 64'd0);
        check("err_hold", {63'd0, o_err}, 64'(m_err));
    endtask

    task automatic random_beat(input bit last);
        int kind, f3, pick;
        bit alt;
        logic [31:0] imm;
        int bounds[14];
        bounds = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, 31, 32, -1, 0,
                   1048574, -1048576, 1048576};
        kind = $urandom_range(0, 9);
        if (kind == 9) kind = $urandom_range(9, 15);
        f3   = $urandom_range(0, 7);
        alt  = ($urandom_range(0, 3) == 0);
        pick = $urandom_range(0, 9);
        if (pick == 0)      imm = $urandom;
        else if (pick == 1) imm = bounds[$urandom_range(0, 13)];
        else begin
            case (kind)
                1:       imm = (f3 == 1 || f3 == 5) ? 32'($urandom_range(0, 31))
                                                    : 32'(int'($urandom_range(0, 4095)) - 2048);
                4:       imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                5:       imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
                7, 8:    imm = $urandom & 32'hFFFFF000;
                default: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            endcase
        end
        send_beat(kind, f3, alt, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), imm, last, 1'b0, 32'd0);
    endtask

    // scoreboard monitor
    logic        stalled_prev = 1'b0;
    logic [63:0] held;
    always @(negedge i_clk) begin
        if (i_rst || !o_mem_valid) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) check("stall_stable", {o_mem_addr, o_mem_data}, held);
            if (i_mem_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_unexpected: got %h expected none", {o_mem_addr, o_mem_data});
                end else begin
                    check("write", {o_mem_addr, o_mem_data}, exp_q.pop_front());
                end
                stalled_prev = 1'b0;
            end else begin
                check("ready_low_in_stall", 64'(o_ready), 64'd0);
                stalled_prev = 1'b1;
                held = {o_mem_addr, o_mem_data};
            end
        end
    end

    // main sequence
    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_mem_valid", 64'(o_mem_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_err", {55'd0, o_err, o_err_cnt}, 64'd0);
        check("rst_addr_data", {o_mem_addr, o_mem_data}, 64'd0);
        check("rst_state", 64'(o_dbg_state), 64'd0);

        // addi x1,x0,5
        start_session(32'h100);
        send_beat(1, 0, 0, 1, 0, 0, 32'd5, 1, 1, 32'h00500093);
        wait_done();

        // sub / lw / sw back to back
        start_session(32'h100);
        send_beat(0, 0, 1, 3, 1, 2, 32'd0, 0, 1, 32'h402081B3);
        send_beat(2, 2, 0, 5, 2, 0, 32'd8, 0, 1, 32'h00812283);
        send_beat(3, 2, 0, 0, 2, 5, 32'd12, 1, 1, 32'h00512623);
        wait_done();

        // beq / jal with the memory stalled
        start_session(32'h200);
        ready_mode = 2;
        fork
            begin
                send_beat(4, 0, 0, 0, 1, 2, -32'sd4, 0, 1, 32'hFE208EE3);
                send_beat(5, 0, 0, 1, 0, 0, 32'd8, 1, 1, 32'h008000EF);
            end
            begin
                repeat (5) @(posedge i_clk);
                ready_mode = 0;
            end
        join
        wait_done();

        // illegal beats interleaved with legal ones
        start_session(32'h300);
        send_beat(1, 0, 0, 2, 0, 0, 32'd7, 0, 0, 32'd0);
        send_beat(9, 0, 0, 1, 1, 1, 32'd0, 0, 0, 32'd0);
        send_beat(1, 1, 0, 1, 1, 0, 32'd32, 0, 0, 32'd0);
        send_beat(0, 0, 0, 4, 1, 2, 32'd0, 0, 0, 32'd0);
        send_beat(4, 0, 0, 0, 1, 2, 32'd3, 0, 0, 32'd0);
        send_beat(1, 0, 0, 1, 0, 0, 32'd2048, 0, 0, 32'd0);
        send_beat(7, 0, 0, 6, 0, 0, 32'h12345000, 1, 0, 32'd0);
        wait_done();
        check("illegal_count_4", 64'(o_err_cnt), 64'd4);

        // address wrap
        start_session(32'hFFFFFFFC);
        send_beat(1, 0, 0, 1, 0, 0, 32'd1, 0, 1, 32'h00100093);
        send_beat(1, 0, 0, 2, 0, 0, 32'd2, 1, 1, 32'h00200113);
        wait_done();

        // reset while a word is stalled
        start_session(32'h400);
        ready_mode = 2;
        send_beat(1, 0, 0, 3, 0, 0, 32'd9, 0, 0, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("mid_rst_mem_valid", 64'(o_mem_valid), 64'd0);
        check("mid_rst_state", 64'(o_dbg_state), 64'd0);
        check("mid_rst_ready", 64'(o_ready), 64'd0);
        exp_q.delete();
        ready_mode = 0;
        start_session(32'h500);
        send_beat(6, 0, 0, 1, 5, 0, -32'sd16, 1, 0, 32'd0);
        wait_done();

        // counter saturation, session ended by an illegal last beat
        start_session(32'h600);
        for (int i = 0; i < 300; i++)
            send_beat($urandom_range(9, 15), 0, 0, 0, 0, 0, 32'd0, i == 299, 0, 32'd0);
        wait_done();
        check("err_cnt_saturated", 64'(o_err_cnt), 64'd255);

        // randomized sessions
        for (int s = 0; s < 10; s++) begin
            int nb;
            ready_mode = $urandom_range(0, 1);
            start_session($urandom);
            nb = $urandom_range(8, 40);
            for (int b = 0; b < nb; b++) random_beat(b == nb - 1);
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
